// File: rtl/led_pwm.sv
// led_pwm: multi-channel PWM LED driver.
//
// Each channel has a duty shadow register written over a simple strobe port. The shadow is
// copied into the active duty register only at a PWM period boundary (wrap), so a waveform
// never changes mid-period. Outputs are registered and active high.
//
// Optional feature (compile-time macro LED_PWM_BREATHE_EN): address NUM_CH writes a per-channel
// breathe mask. A masked channel ramps its active duty by one step per period between 0 and
// its shadow value (the peak) instead of loading the shadow directly.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous reset, active low
//   enable       1 = run; 0 = hold prescaler/counter at 0 and drive outputs low
//   wr_en        register write strobe, one cycle per write
//   wr_addr      0..NUM_CH-1 = duty shadow, NUM_CH = breathe mask (if enabled)
//   wr_data      write data
//   pwm_out      PWM outputs, one per channel, registered
//   period_start one-cycle pulse when a new PWM period begins
module led_pwm #(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned PWM_WIDTH = 8,
  parameter int unsigned PRESCALE  = 64,
  localparam int unsigned AW       = $clog2(NUM_CH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [PWM_WIDTH-1:0] wr_data,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic                 period_start
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]        presc_q, presc_d;
  logic [PWM_WIDTH-1:0] cnt_q, cnt_d;
  logic [PWM_WIDTH-1:0] shadow_q [NUM_CH];
  logic [PWM_WIDTH-1:0] shadow_d [NUM_CH];
  logic [PWM_WIDTH-1:0] active_q [NUM_CH];
  logic [PWM_WIDTH-1:0] active_d [NUM_CH];
  logic [NUM_CH-1:0]    pwm_out_q, pwm_out_d;
  logic                 period_start_q, period_start_d;
  logic                 tick;
  logic                 wrap;

  // With PRESCALE == 1 the prescaler stays at 0 and every cycle is a tick.
  assign tick = (presc_q == PW'(PRESCALE - 1));
  assign wrap = enable && tick && (cnt_q == '1);

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = cnt_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_comb begin
    period_start_d = wrap;
    for (int i = 0; i < NUM_CH; i++) begin
      shadow_d[i]  = shadow_q[i];
      pwm_out_d[i] = enable && (cnt_q < active_q[i]);
      if (wr_en && (wr_addr == AW'(i))) begin
        shadow_d[i] = wr_data;
      end
    end
  end

`ifdef LED_PWM_BREATHE_EN
  // dir_q[i]: 0 = ramping up toward the peak, 1 = ramping down toward 0.
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] dir_q, dir_d;

  always_comb begin
    mask_d = mask_q;
    dir_d  = dir_q;
    if (wr_en && (wr_addr == AW'(NUM_CH))) begin
      mask_d = wr_data[NUM_CH-1:0];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      active_d[i] = active_q[i];
      if (wrap) begin
        if (!mask_q[i]) begin
          active_d[i] = shadow_q[i];
          dir_d[i]    = 1'b0;
        end else if (shadow_q[i] == '0) begin
          active_d[i] = '0;
          dir_d[i]    = 1'b0;
        end else if ((active_q[i] > shadow_q[i]) ||
                     (!dir_q[i] && (active_q[i] == shadow_q[i])) ||
                     (dir_q[i] && (active_q[i] != '0))) begin
          // Step down; heading for 0 until it is reached.
          active_d[i] = active_q[i] - 1'b1;
          dir_d[i]    = (PWM_WIDTH'(active_q[i] - 1'b1) != '0);
        end else begin
          // Step up; flip once the peak is reached.
          active_d[i] = active_q[i] + 1'b1;
          dir_d[i]    = (PWM_WIDTH'(active_q[i] + 1'b1) == shadow_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      dir_q  <= '0;
    end else begin
      mask_q <= mask_d;
      dir_q  <= dir_d;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      active_d[i] = wrap ? shadow_q[i] : active_q[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm.sv
// Directed bench for led_pwm. Two instances share all inputs: u_dut1 with PRESCALE=1
// (256-cycle period) and u_dut4 with PRESCALE=4 (1024-cycle period).
module tb_led_pwm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [2:0] pwm1, pwm4;
  logic       ps1, ps4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  led_pwm #(.NUM_CH(3), .PWM_WIDTH(8), .PRESCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pwm_out(pwm1), .period_start(ps1)
  );

  led_pwm #(.NUM_CH(3), .PWM_WIDTH(8), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .pwm_out(pwm4), .period_start(ps4)
  );

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns at the negedge where period_start is seen high, or ok=0 after limit cycles.
  task automatic wait_ps(input bit sel4, input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if ((sel4 ? ps4 : ps1) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at a period_start negedge: counts high samples over exactly one period.
  task automatic measure(input bit sel4, output int h0, output int h1, output int h2);
    logic [2:0] p;
    h0 = 0;
    h1 = 0;
    h2 = 0;
    repeat (sel4 ? 1024 : 256) begin
      @(negedge clk);
      p = sel4 ? pwm4 : pwm1;
      h0 += int'(p[0]);
      h1 += int'(p[1]);
      h2 += int'(p[2]);
    end
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if (pwm1 !== 3'b000 || pwm4 !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_pwm: got %b/%b expected 000/000", pwm1, pwm4);
    end
    vectors++;
    if (ps1 !== 1'b0 || ps4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ps: got %b/%b expected 0/0", ps1, ps4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_duty;
    bit ok;
    int h0, h1, h2;
    wait_ps(1'b0, 300, ok);
    write_reg(2'd0, 8'd64);
    write_reg(2'd1, 8'd0);
    write_reg(2'd2, 8'd255);
    wait_ps(1'b0, 300, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL duty_wait: period_start got 0 expected 1");
    end
    measure(1'b0, h0, h1, h2);
    vectors++;
    if (h0 !== 64 || h1 !== 0 || h2 !== 255) begin
      miscompares++;
      $display("FAIL duty_a: got %0d/%0d/%0d expected 64/0/255", h0, h1, h2);
    end
    write_reg(2'd0, 8'd1);
    write_reg(2'd2, 8'd128);
    wait_ps(1'b0, 300, ok);
    measure(1'b0, h0, h1, h2);
    vectors++;
    if (h0 !== 1 || h1 !== 0 || h2 !== 128) begin
      miscompares++;
      $display("FAIL duty_b: got %0d/%0d/%0d expected 1/0/128", h0, h1, h2);
    end
  endtask

  // Entered at a dut1 period_start negedge with ch1 active duty 0.
  task automatic test_double_buffer;
    bit ok;
    int h0, h1, h2;
    int rest;
    repeat (100) @(negedge clk);
    write_reg(2'd1, 8'd200);
    rest = 0;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ps1 === 1'b1) begin
        ok = 1'b1;
        break;
      end
      rest += int'(pwm1[1]);
    end
    vectors++;
    if (!ok || rest !== 0) begin
      miscompares++;
      $display("FAIL dbuf_mid: got ok=%0d high=%0d expected ok=1 high=0", ok, rest);
    end
    measure(1'b0, h0, h1, h2);
    vectors++;
    if (h1 !== 200) begin
      miscompares++;
      $display("FAIL dbuf_apply: got %0d expected 200", h1);
    end
    // 255 cycles after period start cnt is 255, so the next edge is the wrap edge.
    repeat (255) @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_data = 8'd50;
    @(negedge clk);
    wr_en = 1'b0;
    vectors++;
    if (ps1 !== 1'b1) begin
      miscompares++;
      $display("FAIL dbuf_coincide_ps: got %b expected 1", ps1);
    end
    measure(1'b0, h0, h1, h2);
    vectors++;
    if (h1 !== 200) begin
      miscompares++;
      $display("FAIL dbuf_coincide_old: got %0d expected 200", h1);
    end
    measure(1'b0, h0, h1, h2);
    vectors++;
    if (h1 !== 50) begin
      miscompares++;
      $display("FAIL dbuf_coincide_new: got %0d expected 50", h1);
    end
  endtask

  task automatic test_prescale;
    bit ok;
    int h0, h1, h2;
    time t0;
    wait_ps(1'b1, 1100, ok);
    t0 = $time;
    write_reg(2'd0, 8'd10);
    write_reg(2'd1, 8'd20);
    write_reg(2'd2, 8'd30);
`ifndef LED_PWM_BREATHE_EN
    // With NUM_CH=3 the 2-bit address tops out at NUM_CH, which must be ignored here.
    write_reg(2'd3, 8'hFF);
`endif
    wait_ps(1'b1, 1100, ok);
    vectors++;
    if (!ok || ($time - t0) / 10 != 1024) begin
      miscompares++;
      $display("FAIL prescale_spacing: got %0d expected 1024", ($time - t0) / 10);
    end
    measure(1'b1, h0, h1, h2);
    vectors++;
    if (h0 !== 40 || h1 !== 80 || h2 !== 120) begin
      miscompares++;
      $display("FAIL prescale_duty: got %0d/%0d/%0d expected 40/80/120", h0, h1, h2);
    end
  endtask

  task automatic test_enable;
    bit ok;
    int h0, h1, h2;
    int bad;
    time t0;
    enable = 1'b0;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (pwm1 !== 3'b000 || pwm4 !== 3'b000 || ps1 !== 1'b0 || ps4 !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL enable_low: got %0d active samples expected 0", bad);
    end
    enable = 1'b1;
    t0 = $time;
    wait_ps(1'b1, 1100, ok);
    vectors++;
    if (!ok || ($time - t0) / 10 != 1024) begin
      miscompares++;
      $display("FAIL enable_restart: got %0d expected 1024", ($time - t0) / 10);
    end
    measure(1'b1, h0, h1, h2);
    vectors++;
    if (h0 !== 40 || h1 !== 80 || h2 !== 120) begin
      miscompares++;
      $display("FAIL enable_duty: got %0d/%0d/%0d expected 40/80/120", h0, h1, h2);
    end
  endtask

  task automatic test_reset_midperiod;
    bit ok;
    int h0, h1, h2;
    write_reg(2'd0, 8'd128);
    wait_ps(1'b0, 300, ok);
    wait_ps(1'b0, 300, ok);
    repeat (20) @(negedge clk);
    vectors++;
    if (pwm1[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_pre: got %b expected 1", pwm1[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (pwm1 !== 3'b000 || pwm4 !== 3'b000 || ps1 !== 1'b0 || ps4 !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_now: got %b/%b ps %b/%b expected 000/000 ps 0/0",
               pwm1, pwm4, ps1, ps4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ps(1'b0, 300, ok);
    measure(1'b0, h0, h1, h2);
    vectors++;
    if (h0 !== 0 || h1 !== 0 || h2 !== 0) begin
      miscompares++;
      $display("FAIL midreset_cleared: got %0d/%0d/%0d expected 0/0/0", h0, h1, h2);
    end
  endtask

`ifdef LED_PWM_BREATHE_EN
  task automatic test_breathe;
    bit ok;
    int h0, h1, h2;
    int exp_seq [7] = '{1, 2, 3, 2, 1, 0, 1};
    write_reg(2'd3, 8'h01);
    write_reg(2'd0, 8'd3);
    wait_ps(1'b0, 300, ok);
    for (int k = 0; k < 7; k++) begin
      measure(1'b0, h0, h1, h2);
      vectors++;
      if (h0 !== exp_seq[k]) begin
        miscompares++;
        $display("FAIL breathe_step%0d: got %0d expected %0d", k, h0, exp_seq[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_duty;
    test_double_buffer;
    test_prescale;
    test_enable;
    test_reset_midperiod;
`ifdef LED_PWM_BREATHE_EN
    test_breathe;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
